// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU command encoding and arbiter FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_OR  = 2'b10,
        ALU_XOR = 2'b11
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// ALU: combinational add-with-carry / and / or / xor; carry-out dropped, cin used by add only.
// Latency 0; no flow control, the caller registers inputs and result.
module ALU
    import alu_pkg::*;
#(
    parameter int bitWidth = 32
) (
    input  logic [bitWidth-1:0] rs1_data_i,
    input  logic [bitWidth-1:0] rs2_data_i,
    input  logic                cin_i,
    input  alu_cmd_t            cmd_i,
    output logic [bitWidth-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (cmd_i)
            ALU_ADD: result_o = rs1_data_i + rs2_data_i + bitWidth'(cin_i);
            ALU_AND: result_o = rs1_data_i & rs2_data_i;
            ALU_OR:  result_o = rs1_data_i | rs2_data_i;
            ALU_XOR: result_o = rs1_data_i ^ rs2_data_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_grant.sv
// rr_grant: combinational one-hot picker searching valid_i from prio_i upward, modulo NB_REQ.
// Latency 0; en_i low suppresses every grant so the caller can stall arbitration.
module rr_grant #(
    parameter int NB_REQ = 4,
    parameter int ID_W   = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]   prio_i,
    input  logic              en_i,
    output logic [NB_REQ-1:0] grant_o,
    output logic [ID_W-1:0]   grant_idx_o
);

    logic [ID_W:0] cand;
    logic          found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            // Extra bit keeps prio+i from overflowing before the wrap for non-power-of-two NB_REQ.
            cand = {1'b0, prio_i} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NB_REQ)) begin
                cand = cand - (ID_W+1)'(NB_REQ);
            end
            if (en_i && !found && valid_i[cand[ID_W-1:0]]) begin
                found                      = 1'b1;
                grant_o[cand[ID_W-1:0]]    = 1'b1;
                grant_idx_o                = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: NB_REQ requesters share one ALU; 2-cycle handshake-to-rsp_valid latency, response held until rsp_ready_i.
// Grants only in IDLE or the RESP drain cycle; ALU_ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest) instead of round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int bitWidth = 32,
    parameter int NB_REQ   = 4,
    parameter int ID_W     = $clog2(NB_REQ)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [NB_REQ-1:0]                req_valid_i,
    output logic [NB_REQ-1:0]                req_ready_o,
    input  logic [NB_REQ-1:0][bitWidth-1:0]  req_rs1_data_i,
    input  logic [NB_REQ-1:0][bitWidth-1:0]  req_rs2_data_i,
    input  logic [NB_REQ-1:0]                req_cin_i,
    input  logic [NB_REQ-1:0][1:0]           req_cmd_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [bitWidth-1:0]              rsp_data_o,
    output logic [ID_W-1:0]                  rsp_id_o,
    output logic                             busy_o
);

    arb_state_t          state_q, state_d;
    logic                grant_en;
    logic                hs;
    logic [NB_REQ-1:0]   grant;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     prio;

    logic [bitWidth-1:0] op_rs1_q, op_rs2_q;
    logic                op_cin_q;
    alu_cmd_t            op_cmd_q;
    logic [ID_W-1:0]     op_id_q;
    logic [bitWidth-1:0] alu_result;

    // The drain cycle doubles as an accept slot, giving one op per 2 cycles when unstalled.
    assign grant_en = (state_q == ARB_IDLE) || ((state_q == ARB_RESP) && rsp_ready_i);

    rr_grant #(
        .NB_REQ (NB_REQ),
        .ID_W   (ID_W)
    ) u_rr_grant (
        .valid_i     (req_valid_i),
        .prio_i      (prio),
        .en_i        (grant_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready_o = grant;
    assign hs          = |grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prio = '0;
`else
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prio <= '0;
        end else if (hs) begin
            prio <= (grant_idx == ID_W'(NB_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (hs) state_d = ARB_EXEC;
            ARB_EXEC: state_d = ARB_RESP;
            ARB_RESP: if (rsp_ready_i) state_d = hs ? ARB_EXEC : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_o = (state_q == ARB_RESP);
        busy_o      = (state_q != ARB_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            op_rs1_q <= '0;
            op_rs2_q <= '0;
            op_cin_q <= 1'b0;
            op_cmd_q <= ALU_ADD;
            op_id_q  <= '0;
        end else if (hs) begin
            op_rs1_q <= req_rs1_data_i[grant_idx];
            op_rs2_q <= req_rs2_data_i[grant_idx];
            op_cin_q <= req_cin_i[grant_idx];
            op_cmd_q <= alu_cmd_t'(req_cmd_i[grant_idx]);
            op_id_q  <= grant_idx;
        end
    end

    ALU #(
        .bitWidth (bitWidth)
    ) u_alu (
        .rs1_data_i (op_rs1_q),
        .rs2_data_i (op_rs2_q),
        .cin_i      (op_cin_q),
        .cmd_i      (op_cmd_q),
        .result_o   (alu_result)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rsp_data_o <= '0;
            rsp_id_o   <= '0;
        end else if (state_q == ARB_EXEC) begin
            rsp_data_o <= alu_result;
            rsp_id_o   <= op_id_q;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed multi-cycle sequences, and a reference-model scoreboard
// that predicts grants, FSM-visible outputs and results every cycle.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic                 clk = 1'b0;
    logic                 reset_n_i;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    logic [N-1:0][W-1:0]  req_rs1_data_i;
    logic [N-1:0][W-1:0]  req_rs2_data_i;
    logic [N-1:0]         req_cin_i;
    logic [N-1:0][1:0]    req_cmd_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [W-1:0]         rsp_data_o;
    logic [IW-1:0]        rsp_id_o;
    logic                 busy_o;

    always #5 clk = ~clk;

    alu_arbiter #(.bitWidth(W), .NB_REQ(N), .ID_W(IW)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rs1_data_i (req_rs1_data_i),
        .req_rs2_data_i (req_rs2_data_i),
        .req_cin_i      (req_cin_i),
        .req_cmd_i      (req_cmd_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_id_o       (rsp_id_o),
        .busy_o         (busy_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] id;
    } rsp_t;
    rsp_t sb[$];

    int           m_state = 0;   // 0 idle, 1 exec, 2 resp
    int           m_prio  = 0;
    logic [N-1:0] hs_vec  = '0;

    function automatic logic [W-1:0] alu_model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic [1:0] cmd);
        case (cmd)
            2'b00:   return a + b + {{(W-1){1'b0}}, c};
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [N-1:0] rr_model(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return 0;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle with settled inputs.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic         allowed;
        int           g;
        rsp_t         e;
        if (!reset_n_i) begin
            m_state = 0;
            m_prio  = 0;
            hs_vec  = '0;
            sb.delete();
        end else begin
            allowed = (m_state == 0) || ((m_state == 2) && rsp_ready_i);
            eg      = allowed ? rr_model(req_valid_i, m_prio) : '0;
            chk("req_ready", req_ready_o, eg);
            chk("ready_onehot0", $onehot0(req_ready_o), 1);
            chk("ready_without_valid", |(req_ready_o & ~req_valid_i), 0);
            chk("rsp_valid", rsp_valid_o, m_state == 2);
            chk("busy", busy_o, m_state != 0);
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rsp_data", rsp_data_o, e.data);
                    chk("sb_rsp_id", rsp_id_o, e.id);
                end
            end
            hs_vec = eg;
            if (|eg) begin
                g = oh_idx(eg);
                e.data = alu_model(req_rs1_data_i[g], req_rs2_data_i[g], req_cin_i[g], req_cmd_i[g]);
                e.id   = IW'(g);
                sb.push_back(e);
`ifdef ALU_ARB_FIXED_PRIO_EN
                m_prio = 0;
`else
                m_prio = (g + 1) % N;
`endif
            end
            case (m_state)
                0:       if (|eg) m_state = 1;
                1:       m_state = 2;
                default: if (rsp_ready_i) m_state = (|eg) ? 1 : 0;
            endcase
        end
    end

    typedef struct {
        int           r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [1:0]   cmd;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vt[7];

    task automatic do_reset();
        reset_n_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n_i = 1'b1;
    endtask

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [1:0] cmd);
        req_valid_i[r]    = 1'b1;
        req_rs1_data_i[r] = a;
        req_rs2_data_i[r] = b;
        req_cin_i[r]      = c;
        req_cmd_i[r]      = cmd;
    endtask

    int gnt_id[5];
    int gnt_cyc[5];
    int n_gnt;
    int exp_id;

    initial begin
        reset_n_i      = 1'b0;
        req_valid_i    = '0;
        req_rs1_data_i = '0;
        req_rs2_data_i = '0;
        req_cin_i      = '0;
        req_cmd_i      = '0;
        rsp_ready_i    = 1'b1;

        vt[0] = '{0, 32'd5,         32'd7,         1'b1, 2'b00, 32'd13};
        vt[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_0000};
        vt[2] = '{2, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b1, 2'b11, 32'h5A5A_A5A5};
        vt[3] = '{3, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 2'b01, 32'h00F0_1200};
        vt[4] = '{1, 32'h1200_0034, 32'h0034_5600, 1'b1, 2'b10, 32'h1234_5634};
        vt[5] = '{2, 32'h8000_0000, 32'h8000_0000, 1'b0, 2'b00, 32'h0000_0000};
        vt[6] = '{3, 32'd100,       32'd200,       1'b0, 2'b00, 32'd300};

        #2;
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_data", rsp_data_o, 0);
        chk("reset_id", rsp_id_o, 0);
        chk("reset_ready", req_ready_o, 0);
        repeat (2) @(posedge clk);
        #3 reset_n_i = 1'b1;

        // Single isolated requests: same-cycle ready, 2-cycle latency, exact result.
        foreach (vt[i]) begin
            @(posedge clk);
            #1 set_req(vt[i].r, vt[i].a, vt[i].b, vt[i].c, vt[i].cmd);
            @(negedge clk);
            chk("vec_ready", req_ready_o, N'(1) << vt[i].r);
            @(posedge clk);
            #1 req_valid_i = '0;
            @(negedge clk);
            chk("vec_exec_no_rsp", rsp_valid_o, 0);
            @(negedge clk);
            chk("vec_rsp_valid", rsp_valid_o, 1);
            chk("vec_data", rsp_data_o, vt[i].exp);
            chk("vec_id", rsp_id_o, vt[i].r);
        end

        // All requesters valid continuously from prio 0.
        do_reset();
        @(posedge clk);
        #1 for (int r = 0; r < N; r++) set_req(r, W'(r * 10), 32'd1, 1'b0, 2'b00);
        n_gnt = 0;
        for (int c = 0; c < 20 && n_gnt < 5; c++) begin
            @(negedge clk);
            if (|req_ready_o) begin
                gnt_id[n_gnt]  = oh_idx(req_ready_o);
                gnt_cyc[n_gnt] = c;
                n_gnt++;
            end
        end
        @(posedge clk);
        #1 req_valid_i = '0;
        chk("rr_grant_count", n_gnt, 5);
        for (int k = 0; k < n_gnt; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = k % N;
`endif
            chk("rr_grant_order", gnt_id[k], exp_id);
            if (k > 0) chk("rr_grant_spacing", gnt_cyc[k] - gnt_cyc[k-1], 2);
        end

        // Backpressure: response held while rsp_ready_i low, req2 accepted in the drain cycle.
        repeat (4) @(posedge clk);
        #1 rsp_ready_i = 1'b0;
        set_req(1, 32'd40, 32'd2, 1'b0, 2'b00);
        @(posedge clk);
        #1 req_valid_i[1] = 1'b0;
        set_req(2, 32'd3, 32'd5, 1'b1, 2'b11);
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid_o, 1);
        chk("bp_data", rsp_data_o, 42);
        chk("bp_id", rsp_id_o, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_data", rsp_data_o, 42);
            chk("bp_hold_id", rsp_id_o, 1);
            chk("bp_hold_ready", req_ready_o, 0);
        end
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_drain_grant", req_ready_o, 4'b0100);
        @(posedge clk);
        #1 req_valid_i[2] = 1'b0;
        @(negedge clk);
        chk("bp_exec_busy", busy_o, 1);
        chk("bp_exec_no_rsp", rsp_valid_o, 0);
        @(negedge clk);
        chk("bp_second_data", rsp_data_o, 6);
        chk("bp_second_id", rsp_id_o, 2);

        // Reset asserted mid-EXEC after a req1 handshake.
        repeat (3) @(posedge clk);
        #1 set_req(1, 32'd9, 32'd9, 1'b0, 2'b00);
        @(posedge clk);
        #2 req_valid_i = '0;
        reset_n_i = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", rsp_valid_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_data", rsp_data_o, 0);
        chk("rst_mid_id", rsp_id_o, 0);
        chk("rst_mid_ready", req_ready_o, 0);
        repeat (2) @(posedge clk);
        #3 reset_n_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid_o, 0);
        end
        @(posedge clk);
        #1 for (int r = 0; r < N; r++) set_req(r, W'(r), 32'd1, 1'b0, 2'b10);
        @(negedge clk);
        chk("rst_first_grant", req_ready_o, 4'b0001);
        @(posedge clk);
        #1 req_valid_i = '0;

        // Random traffic: requesters hold valid and payload until their handshake.
        repeat (4) @(posedge clk);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if (hs_vec[r]) req_valid_i[r] = 1'b0;
                if (!req_valid_i[r] && $urandom_range(0, 2) == 0)
                    set_req(r, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)));
            end
            rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1 req_valid_i = '0;
        rsp_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `ALU` instance between `NB_REQ` requesters, for example the integer-execute slot, address generation and a debug port. Requests are accepted with a valid/ready handshake under round-robin arbitration. Operands are registered, the result is computed, and it is returned on a single response channel tagged with the requester index. The block sits between the issue logic and the ALU; it is the only driver of the ALU inputs.

## Interface
Parameters:
- `bitWidth`, default 32: operand and result width, passed to `ALU`.
- `NB_REQ`, default 4: number of requesters, range 2..16.
- `ID_W`, default `$clog2(NB_REQ)`: width of the requester tag.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock, all state on the rising edge.
- `reset_n_i` in 1: asynchronous active-low reset.
- `req_valid_i` in `NB_REQ`: per-requester request valid.
- `req_ready_o` out `NB_REQ`: per-requester grant/accept, at most one bit high.
- `req_rs1_data_i` in `NB_REQ`×`bitWidth`: operand 1 per requester.
- `req_rs2_data_i` in `NB_REQ`×`bitWidth`: operand 2 per requester.
- `req_cin_i` in `NB_REQ`: carry-in per requester.
- `req_cmd_i` in `NB_REQ`×2: ALU command per requester (00 add, 01 and, 10 or, 11 xor).
- `rsp_valid_o` out 1: result valid.
- `rsp_ready_i` in 1: consumer accepts result.
- `rsp_data_o` out `bitWidth`: result.
- `rsp_id_o` out `ID_W`: index of the requester that owns the result.
- `busy_o` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on a request handshake.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when `rsp_ready_i` is high and no request is granted.
  - RESP → EXEC when `rsp_ready_i` is high and a request is granted in the same cycle.
  - RESP holds while `rsp_ready_i` is low.
- Grant is allowed only in IDLE, or in RESP with `rsp_ready_i` high. `req_ready_o[g]` is combinational from `req_valid_i`, the priority pointer and the state. It is never high for a non-valid requester.
- Handshake on requester g means `req_valid_i[g]` and `req_ready_o[g]` are both high. On the handshake, the operands, cin, cmd and g are captured into operand registers.
- Requester rules: a requester must not make valid depend on ready. Once valid is high, the requester holds valid and payload stable until the handshake.
- EXEC: the ALU is fed from the operand registers. Its output is captured into `rsp_data_o`, and the captured g goes to `rsp_id_o`.
- RESP: `rsp_valid_o` is high. The result and id are held stable until the response handshake (`rsp_valid_o` and `rsp_ready_i` both high).
- Round-robin: pointer `prio` points to the highest-priority index. Search is `prio`, `prio+1`, and so on, modulo `NB_REQ`. On each handshake, `prio` becomes g+1, wrapping from `NB_REQ`-1 to 0. `prio` is unchanged when there is no handshake.
- Arithmetic: add is rs1+rs2+cin modulo 2^`bitWidth`; the carry-out is discarded (all-ones + 1 + 0 = 0). cin is ignored for and/or/xor.
- Reset values (asserted at any time, including mid-EXEC or RESP): state IDLE, `prio` 0, `req_ready_o` 0, `rsp_valid_o` 0, `rsp_data_o` 0, `rsp_id_o` 0, `busy_o` 0. An in-flight operation is dropped without a response.

## Timing
- Request accepted at edge N → EXEC in cycle N+1 → `rsp_valid_o` high from cycle N+2.
- Latency is 2 cycles from handshake to `rsp_valid_o`.
- With `rsp_ready_i` tied high, peak throughput is one operation per 2 cycles; a new request is accepted in the RESP drain cycle.
- All outputs are registered except `req_ready_o`, which is combinational from `req_valid_i`.
- Reset deassertion is synchronised externally; the block assumes `reset_n_i` is released away from the `clk_i` edge.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority, index 0 highest. The `prio` register is not implemented and the search always starts at 0.
- Not defined: round-robin as described above.
- In both cases the interface, latency and reset behaviour are identical.

## Structure
- Package `alu_pkg`:
  - `alu_cmd_t` enum (`ALU_ADD`=2'b00, `ALU_AND`, `ALU_OR`, `ALU_XOR`).
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`).
- Sub-module `rr_grant` (parameter `NB_REQ`): purely combinational. It takes the valid vector, `prio` and an enable, and outputs a one-hot grant and its encoded index. It is reused by other arbiters in the core.
- The `ALU` is instantiated directly in `alu_arbiter`.

## Test plan
- Single request: req0 add, rs1=5, rs2=7, cin=1, `rsp_ready_i`=1 → `req_ready_o`=0001 in the same cycle; `rsp_valid_o` 2 cycles later with data=13 and id=0.
- All four requesters valid continuously, `rsp_ready_i`=1, prio=0 → grant order 0,1,2,3,0 with one grant every 2 cycles. With `ALU_ARB_FIXED_PRIO_EN`, every grant goes to 0.
- Backpressure: `rsp_ready_i`=0 for 5 cycles → data and id held, `req_ready_o`=0 throughout. Releasing `rsp_ready_i` while req2 is valid → handshake on req2 in the drain cycle, followed by EXEC.
- Wrap: add 0xFFFFFFFF + 0 with cin=1 → data 0x00000000. Xor 0xA5A5A5A5 with 0xFFFF0000 and cin=1 → 0x5A5AA5A5.
- Reset mid-EXEC: assert `reset_n_i` low asynchronously → all outputs 0 immediately, no response issued, first grant after release goes to req0.
- Protocol check: random valid/stall traffic for 10k cycles → no lost or duplicate responses, at most one ready high, and `req_ready_o` never high without the corresponding valid.
